// File: rtl/regread_arbiter.sv
// Round-robin arbiter and two-stage sequencer for a shared register-file read port.
// Optional write-to-read forwarding is enabled by defining REGARB_BYPASS_EN.
module regread_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     mux_sel,
  input  logic [DW-1:0]     mux_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_id,
  output logic [DW-1:0]     rsp_data,
  input  logic              rsp_ready
`ifdef REGARB_BYPASS_EN
  ,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DW-1:0]     wr_data
`endif
);

  logic          run_q;
  logic          s1_valid_q, s1_valid_d;
  logic [AW-1:0] s1_addr_q, s1_addr_d;
  logic [1:0]    s1_id_q, s1_id_d;
  logic [1:0]    last_q, last_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_id_q, rsp_id_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic          s2_load;
  logic          s1_free;
  logic          hit;
  logic          gnt;
  logic [1:0]    gnt_idx;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] cap_data;

  assign s2_load = s1_valid_q & (~rsp_valid_q | rsp_ready);
  assign s1_free = ~s1_valid_q | s2_load;

  // Scan starts one past the last winner and wraps.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!hit && req_valid[i] &&
            i == (int'(last_q) + k) % NREQ) begin
          hit     = 1'b1;
          gnt_idx = 2'(i);
        end
      end
    end
  end

  assign gnt = hit & s1_free & run_q;

  always_comb begin
    req_ready = '0;
    gnt_addr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        req_ready[i] = gnt;
        gnt_addr     = req_addr[i*AW +: AW];
      end
    end
  end

  always_comb begin
    cap_data = (s1_addr_q == '0) ? '0 : mux_data;
`ifdef REGARB_BYPASS_EN
    if (wr_en && wr_addr == s1_addr_q && s1_addr_q != '0)
      cap_data = wr_data;
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_addr_d  = s1_addr_q;
    s1_id_d    = s1_id_q;
    last_d     = last_q;
    if (gnt) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = gnt_addr;
      s1_id_d    = gnt_idx;
      last_d     = gnt_idx;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = s1_id_q;
      rsp_data_d  = cap_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_id_q     <= '0;
      last_q      <= 2'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      run_q       <= 1'b1;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_id_q     <= s1_id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign mux_sel   = s1_addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_regread_arbiter.sv
// Self-checking bench for regread_arbiter: vector table, scoreboard,
// and directed backpressure / reset / register-zero sequences.
module tb_regread_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]   req_ready;
  logic [AW-1:0]     mux_sel;
  logic [DW-1:0]     mux_data;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready = 1'b1;
`ifdef REGARB_BYPASS_EN
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
`endif

  logic [DW-1:0] mem [32];
  assign mux_data = mem[mux_sel];

  always #5 clk = ~clk;

  regread_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .mux_sel   (mux_sel),
    .mux_data  (mux_data),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
`ifdef REGARB_BYPASS_EN
    ,
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
`endif
  );

  int total = 0;
  int bad   = 0;
  int nrsp  = 0;
  bit sb_en = 1'b1;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [2:0]  v;
    logic [14:0] a;
    logic [2:0]  r;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    repeat (2) cyc();
    req_valid = '0;
    reset_n   = 1'b1;
    repeat (2) cyc();
  endtask

  // Scoreboard: expectation pushed on each accepted grant, checked on each response.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sbq.delete();
    end else if (sb_en) begin
      if (rsp_valid && rsp_ready) begin
        nrsp++;
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_extra: unexpected rsp id=%0d data=%h", rsp_id, rsp_data);
        end else begin
          e = sbq.pop_front();
          chk("sb_id", 32'(rsp_id), 32'(e.id));
          chk("sb_data", rsp_data, e.d);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          logic [4:0] a;
          a = req_addr[i*AW +: AW];
          e.id = 2'(i);
          e.d  = (a == 5'd0) ? 32'd0 : mem[a];
          sbq.push_back(e);
        end
      end
    end
  end

  initial begin
    int n0;
    for (int r = 0; r < 32; r++) mem[r] = 32'hA5A5_0000 | 32'(r * 16'h0101);
    mem[0] = 32'hFFFF_FFFF;
    mem[7] = 32'hDEAD_BEEF;

    tbl[0]  = '{3'b111, 15'd0, 3'b001};
    tbl[1]  = '{3'b111, 15'd0, 3'b010};
    tbl[2]  = '{3'b111, 15'd0, 3'b100};
    tbl[3]  = '{3'b111, 15'd0, 3'b001};
    tbl[4]  = '{3'b111, 15'd0, 3'b010};
    tbl[5]  = '{3'b111, 15'd0, 3'b100};
    tbl[6]  = '{3'b101, 15'd0, 3'b001};
    tbl[7]  = '{3'b101, 15'd0, 3'b100};
    tbl[8]  = '{3'b010, 15'd0, 3'b010};
    tbl[9]  = '{3'b000, 15'd0, 3'b000};
    tbl[10] = '{3'b011, 15'd0, 3'b001};
    tbl[11] = '{3'b110, 15'd0, 3'b010};
    tbl[12] = '{3'b110, 15'd0, 3'b100};
    for (int i = 0; i < 13; i++)
      tbl[i].a = {5'(3*i+2), 5'(3*i+1), 5'(3*i)};

    // Reset state, observed with all requesters asserting.
    reset_n   = 1'b0;
    req_valid = 3'b111;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mux_sel", 32'(mux_sel), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    do_reset();

    // Single request: grant at G, response at G+2.
    req_addr  = {5'd0, 5'd0, 5'd7};
    req_valid = 3'b001;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'b001);
    cyc();
    req_valid = '0;
    @(negedge clk);
    chk("single_g1_valid", 32'(rsp_valid), 32'd0);
    chk("single_g1_msel", 32'(mux_sel), 32'd7);
    cyc();
    @(negedge clk);
    chk("single_g2_valid", 32'(rsp_valid), 32'd1);
    chk("single_g2_id", 32'(rsp_id), 32'd0);
    chk("single_g2_data", rsp_data, 32'hDEAD_BEEF);
    cyc();
    repeat (2) cyc();

    // Round-robin vector table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req_valid = tbl[i].v;
      req_addr  = tbl[i].a;
      @(negedge clk);
      chk($sformatf("rr_ready[%0d]", i), 32'(req_ready), 32'(tbl[i].r));
      cyc();
    end
    req_valid = '0;
    repeat (4) cyc();
    chk("rr_drained", 32'(sbq.size()), 32'd0);

    // Register zero reads as zero.
    req_addr  = {5'd4, 5'd0, 5'd4};
    req_valid = 3'b010;
    @(negedge clk);
    chk("r0_ready", 32'(req_ready), 32'b010);
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    chk("r0_valid", 32'(rsp_valid), 32'd1);
    chk("r0_id", 32'(rsp_id), 32'd1);
    chk("r0_data", rsp_data, 32'd0);
    repeat (3) cyc();

    // Backpressure: three grants, then consumer stalls with S1 and S2 full.
    do_reset();
    n0 = nrsp;
    req_addr  = {5'd12, 5'd11, 5'd10};
    req_valid = 3'b111;
    repeat (3) cyc();
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_data", rsp_data, mem[11]);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_msel", 32'(mux_sel), 32'd12);
      cyc();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) cyc();
    chk("bp_count", 32'(nrsp - n0), 32'd3);
    chk("bp_drained", 32'(sbq.size()), 32'd0);

    // Reset one cycle after a grant discards the in-flight read.
    n0 = nrsp;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_valid = 3'b001;
    @(negedge clk);
    chk("mr_ready", 32'(req_ready), 32'b001);
    cyc();
    reset_n   = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    cyc();
    req_valid = '0;
    reset_n   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mr_quiet", 32'(rsp_valid), 32'd0);
      cyc();
    end
    chk("mr_no_rsp", 32'(nrsp - n0), 32'd0);
    req_valid = 3'b111;
    @(negedge clk);
    chk("mr_first", 32'(req_ready), 32'b001);
    cyc();
    req_valid = '0;
    repeat (4) cyc();
    chk("mr_drained", 32'(sbq.size()), 32'd0);

`ifdef REGARB_BYPASS_EN
    sb_en  = 1'b0;
    mem[9] = 32'd0;
    req_addr  = {5'd0, 5'd0, 5'd9};
    req_valid = 3'b001;
    cyc();
    req_valid = '0;
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h1234_5678;
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    chk("byp_data", rsp_data, 32'h1234_5678);
    cyc();
    req_addr  = {5'd0, 5'd0, 5'd0};
    req_valid = 3'b001;
    cyc();
    req_valid = '0;
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hCAFE_F00D;
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    chk("byp_r0", rsp_data, 32'd0);
    repeat (3) cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
